// File: rtl/hue_sequencer.sv
// Colour-wheel sequencer: sweeps three PWM duty values around six hue sectors,
// one ramp step every TICKS_PER_STEP enabled clocks.
module hue_sequencer #(
  parameter int TICKS_PER_STEP = 120000,
  parameter int DUTY_MAX       = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       restart,
  output logic [6:0] duty_r,
  output logic [6:0] duty_g,
  output logic [6:0] duty_b,
  output logic [2:0] sector,
  output logic       step,
  output logic       wrap
);

  localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_STEP - 1);
  localparam logic [6:0]  RAMP_LAST = 7'(DUTY_MAX - 1);
  localparam logic [6:0]  FULL      = 7'(DUTY_MAX);

  logic [31:0] r_cnt;
  logic [6:0]  r_ramp;
  logic [2:0]  r_sector;
  logic        r_step;
  logic        r_wrap;

  logic [31:0] w_cnt_nxt;
  logic [6:0]  w_ramp_nxt;
  logic [2:0]  w_sector_nxt;
  logic        w_step_nxt;
  logic        w_wrap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_ramp   <= '0;
      r_sector <= '0;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_ramp   <= w_ramp_nxt;
      r_sector <= w_sector_nxt;
      r_step   <= w_step_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  // Priority: restart, then freeze on en=0, then run.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_ramp_nxt   = r_ramp;
    w_sector_nxt = r_sector;
    w_step_nxt   = 1'b0;
    w_wrap_nxt   = 1'b0;
    if (restart) begin
      w_cnt_nxt    = '0;
      w_ramp_nxt   = '0;
      w_sector_nxt = '0;
    end else if (en) begin
      if (r_cnt < TICK_LAST) begin
        w_cnt_nxt = r_cnt + 32'd1;
      end else begin
        w_cnt_nxt  = '0;
        w_step_nxt = 1'b1;
        if (r_sector > 3'd5) begin
          // Corrupt sector is repaired at the first step.
          w_sector_nxt = '0;
          w_ramp_nxt   = '0;
        end else if (!dir) begin
          if (r_ramp < RAMP_LAST) begin
            w_ramp_nxt = r_ramp + 7'd1;
          end else begin
            w_ramp_nxt = '0;
            if (r_sector == 3'd5) begin
              w_sector_nxt = '0;
              w_wrap_nxt   = 1'b1;
            end else begin
              w_sector_nxt = r_sector + 3'd1;
            end
          end
        end else begin
          if (r_ramp != 7'd0) begin
            w_ramp_nxt = r_ramp - 7'd1;
          end else begin
            w_ramp_nxt = RAMP_LAST;
            if (r_sector == 3'd0) begin
              w_sector_nxt = 3'd5;
              w_wrap_nxt   = 1'b1;
            end else begin
              w_sector_nxt = r_sector - 3'd1;
            end
          end
        end
      end
    end
  end

  logic [6:0] w_up;
  logic [6:0] w_dn;

  assign w_up = r_ramp;
  assign w_dn = FULL - r_ramp;

  always_comb begin
    duty_r = FULL;
    duty_g = w_up;
    duty_b = '0;
    case (r_sector)
      3'd1: begin duty_r = w_dn; duty_g = FULL; duty_b = '0;   end
      3'd2: begin duty_r = '0;   duty_g = FULL; duty_b = w_up; end
      3'd3: begin duty_r = '0;   duty_g = w_dn; duty_b = FULL; end
      3'd4: begin duty_r = w_up; duty_g = '0;   duty_b = FULL; end
      3'd5: begin duty_r = FULL; duty_g = '0;   duty_b = w_dn; end
      default: begin duty_r = FULL; duty_g = w_up; duty_b = '0; end
    endcase
  end

  assign sector = (r_sector > 3'd5) ? 3'd0 : r_sector;
  assign step   = r_step;
  assign wrap   = r_wrap;

endmodule
